// File: rtl/i2c_slave.sv
// i2c_slave: I2C responder with START/STOP decode, 7-bit address match,
// byte receive/transmit and ACK generation, oversampled on clk.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority
// filter ahead of the sclk/sda_in sampling registers (2 extra clk latency).
module i2c_slave #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       sda_in,
   output logic       sda_out,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       rd_req,
   output logic       busy,
   output logic [3:0] state
);

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 3;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ADDR     = 4'd1,
      S_ADDR_ACK = 4'd2,
      S_RX       = 4'd3,
      S_RX_ACK   = 4'd4,
      S_TX       = 4'd5,
      S_TX_ACK   = 4'd6,
      S_IGNORE   = 4'd7
   } state_t;

   logic          w_scl_in, w_sda_in;
   logic          r_scl_q, r_scl_qq, r_sda_q, r_sda_qq;
   logic          w_rise, w_fall, w_start, w_stop;

   state_t        r_state, w_state_n;
   logic [DW-1:0] r_shift, w_shift_n;
   logic [DW-1:0] r_tx, w_tx_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic          r_full, w_full_n;
   logic          r_rw, w_rw_n;
   logic          r_sda_out, w_sda_n;
   logic [DW-1:0] r_data_out, w_dout_n;
   logic          r_dv, w_dv_n;
   logic          r_rd, w_rd_n;
   logic          r_busy, w_busy_n;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [2:0] r_scl_f, r_sda_f;

   // Majority-of-three history registers for the raw bus pins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_f <= 3'b111;
         r_sda_f <= 3'b111;
      end else begin
         r_scl_f <= {r_scl_f[1:0], sclk};
         r_sda_f <= {r_sda_f[1:0], sda_in};
      end
   end

   assign w_scl_in = (r_scl_f[0] & r_scl_f[1]) | (r_scl_f[0] & r_scl_f[2]) | (r_scl_f[1] & r_scl_f[2]);
   assign w_sda_in = (r_sda_f[0] & r_sda_f[1]) | (r_sda_f[0] & r_sda_f[2]) | (r_sda_f[1] & r_sda_f[2]);
`else
   assign w_scl_in = sclk;
   assign w_sda_in = sda_in;
`endif

   // Two-stage sampling of the bus; resets to the idle-high bus level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_q  <= 1'b1;
         r_scl_qq <= 1'b1;
         r_sda_q  <= 1'b1;
         r_sda_qq <= 1'b1;
      end else begin
         r_scl_q  <= w_scl_in;
         r_scl_qq <= r_scl_q;
         r_sda_q  <= w_sda_in;
         r_sda_qq <= r_sda_q;
      end
   end

   assign w_rise  =  r_scl_q & ~r_scl_qq;
   assign w_fall  = ~r_scl_q &  r_scl_qq;
   assign w_start =  r_scl_q &  r_scl_qq & ~r_sda_q &  r_sda_qq;
   assign w_stop  =  r_scl_q &  r_scl_qq &  r_sda_q & ~r_sda_qq;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_tx       <= '0;
         r_cnt      <= '0;
         r_full     <= 1'b0;
         r_rw       <= 1'b0;
         r_sda_out  <= 1'b1;
         r_data_out <= '0;
         r_dv       <= 1'b0;
         r_rd       <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_shift    <= w_shift_n;
         r_tx       <= w_tx_n;
         r_cnt      <= w_cnt_n;
         r_full     <= w_full_n;
         r_rw       <= w_rw_n;
         r_sda_out  <= w_sda_n;
         r_data_out <= w_dout_n;
         r_dv       <= w_dv_n;
         r_rd       <= w_rd_n;
         r_busy     <= w_busy_n;
      end
   end

   // Next-state and output logic; bus conditions override bit events
   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_tx_n    = r_tx;
      w_cnt_n   = r_cnt;
      w_full_n  = r_full;
      w_rw_n    = r_rw;
      w_sda_n   = r_sda_out;
      w_dout_n  = r_data_out;
      w_dv_n    = 1'b0;
      w_rd_n    = 1'b0;
      w_busy_n  = r_busy;

      if (w_stop) begin
         w_state_n = S_IDLE;
         w_sda_n   = 1'b1;
         w_busy_n  = 1'b0;
         w_cnt_n   = '0;
         w_full_n  = 1'b0;
      end else if (w_start) begin
         w_state_n = S_ADDR;
         w_sda_n   = 1'b1;
         w_busy_n  = 1'b1;
         w_cnt_n   = '0;
         w_full_n  = 1'b0;
      end else begin
         case (r_state)
            S_ADDR, S_RX: begin
               if (w_rise) begin
                  w_shift_n = {r_shift[DW-2:0], r_sda_q};
                  w_cnt_n   = r_cnt + CW'(1);
                  if (r_cnt == CW'(7)) w_full_n = 1'b1;
               end else if (w_fall && r_full) begin
                  w_full_n = 1'b0;
                  if (r_state == S_RX) begin
                     w_dout_n  = r_shift;
                     w_dv_n    = 1'b1;
                     w_sda_n   = 1'b0;
                     w_state_n = S_RX_ACK;
                  end else if (r_shift[DW-1:1] == ADDR) begin
                     w_rw_n    = r_shift[0];
                     w_sda_n   = 1'b0;
                     w_state_n = S_ADDR_ACK;
                  end else begin
                     w_state_n = S_IGNORE;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_fall) begin
                  w_cnt_n = '0;
                  if (r_rw) begin
                     w_tx_n    = {data_in[DW-2:0], 1'b0};
                     w_sda_n   = data_in[DW-1];
                     w_rd_n    = 1'b1;
                     w_state_n = S_TX;
                  end else begin
                     w_sda_n   = 1'b1;
                     w_state_n = S_RX;
                  end
               end
            end
            S_RX_ACK: begin
               if (w_fall) begin
                  w_sda_n   = 1'b1;
                  w_cnt_n   = '0;
                  w_state_n = S_RX;
               end
            end
            S_TX: begin
               // bit 7 went out on entry; falls 0..6 shift out bits 6..0
               if (w_fall) begin
                  w_cnt_n = r_cnt + CW'(1);
                  if (r_cnt == CW'(7)) begin
                     w_sda_n   = 1'b1;
                     w_state_n = S_TX_ACK;
                  end else begin
                     w_sda_n = r_tx[DW-1];
                     w_tx_n  = {r_tx[DW-2:0], 1'b0};
                  end
               end
            end
            S_TX_ACK: begin
               if (w_rise && r_sda_q) begin
                  w_state_n = S_IGNORE;
               end else if (w_fall) begin
                  w_tx_n    = {data_in[DW-2:0], 1'b0};
                  w_sda_n   = data_in[DW-1];
                  w_rd_n    = 1'b1;
                  w_cnt_n   = '0;
                  w_state_n = S_TX;
               end
            end
            S_IGNORE: begin
               w_sda_n = 1'b1;
            end
            default: begin
               w_state_n = S_IDLE;
            end
         endcase
      end
   end

   assign sda_out    = r_sda_out;
   assign data_out   = r_data_out;
   assign data_valid = r_dv;
   assign rd_req     = r_rd;
   assign busy       = r_busy;
   assign state      = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master sequences against i2c_slave.
module tb_i2c_slave;

   localparam int Q = 6;   // clk cycles per quarter sclk period

   logic       clk;
   logic       rst;
   logic       sclk;
   logic       m_sda;
   logic       sda_bus;
   logic       sda_out;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       rd_req;
   logic       busy;
   logic [3:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   int dv_cnt  = 0;
   int rd_cnt  = 0;
   int low_cnt = 0;
   int both_cnt = 0;

   assign sda_bus = m_sda & sda_out;

   i2c_slave #(.ADDR(7'h50)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .sda_in     (sda_bus),
      .sda_out    (sda_out),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .rd_req     (rd_req),
      .busy       (busy),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse and drive monitors
   always @(posedge clk) begin
      if (data_valid) dv_cnt <= dv_cnt + 1;
      if (rd_req) rd_cnt <= rd_cnt + 1;
      if (!sda_out) low_cnt <= low_cnt + 1;
      if (data_valid && rd_req) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; wq();
      sclk  = 1'b1; wq();
      m_sda = 1'b0; wq();
      sclk  = 1'b0; wq();
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; wq();
      sclk  = 1'b1; wq();
      m_sda = 1'b1; wq();
      wq();
   endtask

   task automatic send_bit(input logic b, output logic s);
      m_sda = b;    wq();
      sclk  = 1'b1; wq();
      s = sda_bus;  wq();
      sclk  = 1'b0; wq();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, ack);
   endtask

   task automatic read_bits(output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         b[i] = s;
      end
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] rb;
      int         dv0, rd0, low0;

      rst = 1'b1; sclk = 1'b1; m_sda = 1'b1; data_in = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_sda_out", int'(sda_out), 1);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_data_valid", int'(data_valid), 0);
      chk("rst_rd_req", int'(rd_req), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_state", int'(state), 0);

      // write 0xA6 to 0x50
      dv0 = dv_cnt;
      bus_start();
      chk("wr_busy_after_start", int'(busy), 1);
      chk("wr_state_addr", int'(state), 1);
      write_byte(8'hA0, ack);
      chk("wr_addr_ack", int'(ack), 0);
      chk("wr_state_rx", int'(state), 3);
      write_byte(8'hA6, ack);
      chk("wr_data_ack", int'(ack), 0);
      chk("wr_data_out", int'(data_out), 8'hA6);
      chk("wr_dv_pulses", dv_cnt - dv0, 1);
      bus_stop();
      chk("wr_busy_after_stop", int'(busy), 0);
      chk("wr_state_idle", int'(state), 0);

      // read 0xF6 from 0x50 with master NACK
      rd0 = rd_cnt;
      data_in = 8'hF6;
      bus_start();
      write_byte(8'hA1, ack);
      chk("rd_addr_ack", int'(ack), 0);
      read_bits(rb);
      chk("rd_byte", int'(rb), 8'hF6);
      send_bit(1'b1, s);
      chk("rd_state_ignore", int'(state), 7);
      chk("rd_req_pulses", rd_cnt - rd0, 1);
      bus_stop();
      chk("rd_state_idle", int'(state), 0);

      // two-byte read, master ACKs the first
      rd0 = rd_cnt;
      data_in = 8'h5A;
      bus_start();
      write_byte(8'hA1, ack);
      chk("mrd_addr_ack", int'(ack), 0);
      read_bits(rb);
      chk("mrd_byte0", int'(rb), 8'h5A);
      data_in = 8'h3C;
      send_bit(1'b0, s);
      chk("mrd_state_tx", int'(state), 5);
      read_bits(rb);
      chk("mrd_byte1", int'(rb), 8'h3C);
      send_bit(1'b1, s);
      chk("mrd_rd_pulses", rd_cnt - rd0, 2);
      bus_stop();

      // address mismatch
      dv0 = dv_cnt; low0 = low_cnt;
      bus_start();
      write_byte(8'hA2, ack);
      chk("mis_addr_nack", int'(ack), 1);
      chk("mis_state_ignore", int'(state), 7);
      write_byte(8'hFF, ack);
      chk("mis_data_nack", int'(ack), 1);
      chk("mis_never_low", low_cnt - low0, 0);
      chk("mis_no_dv", dv_cnt - dv0, 0);
      chk("mis_data_out", int'(data_out), 8'hA6);
      bus_stop();

      // repeated start drops a partial byte
      dv0 = dv_cnt;
      data_in = 8'h81;
      bus_start();
      write_byte(8'hA0, ack);
      chk("rs_wr_ack", int'(ack), 0);
      send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
      bus_start();
      chk("rs_state_addr", int'(state), 1);
      write_byte(8'hA1, ack);
      chk("rs_rd_ack", int'(ack), 0);
      chk("rs_state_tx", int'(state), 5);
      chk("rs_no_dv", dv_cnt - dv0, 0);
      chk("rs_data_out", int'(data_out), 8'hA6);
      read_bits(rb);
      chk("rs_byte", int'(rb), 8'h81);
      send_bit(1'b1, s);
      bus_stop();

      // reset in the middle of a received byte
      dv0 = dv_cnt;
      bus_start();
      write_byte(8'hA0, ack);
      chk("rr_addr_ack", int'(ack), 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, s);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rr_sda_out", int'(sda_out), 1);
      chk("rr_state", int'(state), 0);
      chk("rr_busy", int'(busy), 0);
      chk("rr_data_out", int'(data_out), 0);
      chk("rr_data_valid", int'(data_valid), 0);
      chk("rr_rd_req", int'(rd_req), 0);
      for (int i = 0; i < 3; i++) send_bit(1'b0, s);
      send_bit(1'b1, ack);
      chk("rr_ack_ignored", int'(ack), 1);
      chk("rr_state_idle", int'(state), 0);
      chk("rr_no_dv", dv_cnt - dv0, 0);
      bus_stop();

      chk("dv_rd_exclusive", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
